// File: rtl/pc_fetch.sv
// pc_fetch: instruction-fetch initiator for the combinational PC-ROM.
// It owns the PC, drives the ROM word address and captures the returned word
// into a single registered output slot that decode drains through a handshake.
// It supports redirect (branch/jump), halt and 32-bit wrap-around of the PC.
//
// Optional build macro:
//   MISALIGN_TRAP_EN
//     When defined, a misaligned redirect target sets the sticky misalign_err
//     flag and parks the fetcher in HALT.
//     When undefined, the misalign_err port does not exist and the low two
//     bits of redirect_pc are ignored.
//
// Handshake (slot -> decode):
//   if_valid says the slot holds an instruction. A beat transfers on any
//   rising edge where if_valid && if_ready.
//   While if_valid=1 && if_ready=0, the slot contents (if_pc, if_instr) and
//   the PC are held stable. The only exceptions are a redirect, which
//   flushes the slot, and reset.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             halt,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_instr,
  output logic [CNT_W-1:0] fetch_count
`ifdef MISALIGN_TRAP_EN
  ,
  output logic             misalign_err
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        accept;
  logic        fire;
  logic        resume_ok;

  // The ROM is addressed directly from the PC register.
  assign imem_addr = pc;

  // A beat leaves the slot this cycle.
  assign accept = if_valid && if_ready;

  // A new word is loaded when running and the slot is empty or being drained.
  assign fire = (state == ST_RUN) && (!if_valid || if_ready);

`ifdef MISALIGN_TRAP_EN
  // After a misaligned redirect, only an aligned redirect may restart fetching.
  assign resume_ok = !misalign_err;
`else
  logic unused_redirect_lsbs;

  assign resume_ok            = 1'b1;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  // PC, state machine, output slot and beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_pc       <= 32'h0000_0000;
      if_instr    <= 32'h0000_0000;
      fetch_count <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      // Every accepted beat is counted, whatever the state or redirect.
      if (accept) begin
        fetch_count <= fetch_count + CNT_W'(1);
      end

      unique case (state)
        ST_BOOT: begin
          // One settling cycle after reset; halt and redirect are ignored here.
          state <= ST_RUN;
        end

        default: begin
          if (redirect_valid) begin
            // Redirect wins over fetch: flush the slot and restart at the target.
            if_valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            pc <= redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
              misalign_err <= 1'b1;
              state        <= ST_HALT;
            end else begin
              state <= ST_RUN;
            end
`else
            pc    <= {redirect_pc[31:2], 2'b00};
            state <= ST_RUN;
`endif
          end else begin
            if (fire) begin
              if_instr <= imem_rdata;
              if_pc    <= pc;
              if_valid <= 1'b1;
              pc       <= pc + 32'd4;
            end else if (accept) begin
              // Halted: the last beat drains and the slot empties.
              if_valid <= 1'b0;
            end

            if ((state == ST_RUN) && halt) begin
              state <= ST_HALT;
            end else if ((state == ST_HALT) && !halt && resume_ok) begin
              state <= ST_RUN;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: self-checking bench for pc_fetch.
// The bench has four parts:
//   1. A table of cycle vectors covering boot, backpressure, redirect, halt
//      and wrap-around.
//   2. A hand-written misaligned-redirect sequence.
//   3. An asynchronous reset applied mid-stream.
//   4. A randomized run checked against a stream-level model: the expected
//      next pc is kept in exp_q.
// Behaviour follows MISALIGN_TRAP_EN when that macro is defined.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] fetch_count;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  // Scoreboard: the expected pc of the next beat to be accepted.
  logic [31:0] exp_q[$];

  typedef struct {
    logic        ready;
    logic        hlt;
    logic        rv;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_cnt;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  pc_fetch #(
    .RESET_PC(32'h0000_0000),
    .CNT_W   (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .fetch_count   (fetch_count)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign_err  (misalign_err)
`endif
  );

  // ROM model: the word at byte address 4*i holds i.
  assign imem_rdata = {2'b00, imem_addr[31:2]};

  // ---------------------------------------------------------------------
  // Clock generation
  // ---------------------------------------------------------------------
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Driver and checker tasks
  // ---------------------------------------------------------------------

  task automatic drive(
    input logic        r,
    input logic        h,
    input logic        rv,
    input logic [31:0] rp
  );
    if_ready       = r;
    halt           = h;
    redirect_valid = rv;
    redirect_pc    = rp;
  endtask

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(
    input logic        r,
    input logic        h,
    input logic        rv,
    input logic [31:0] rp,
    input logic        ev,
    input logic [31:0] epc,
    input logic [31:0] ein,
    input logic [31:0] ecnt,
    input logic [31:0] eaddr
  );
    vec_t v;
    v.ready   = r;
    v.hlt     = h;
    v.rv      = rv;
    v.rpc     = rp;
    v.e_valid = ev;
    v.e_pc    = epc;
    v.e_instr = ein;
    v.e_cnt   = ecnt;
    v.e_addr  = eaddr;
    vecs.push_back(v);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_valid"}, {31'b0, if_valid}, 32'h0);
    chk({tag, "_pc"},    if_pc,       32'h0);
    chk({tag, "_instr"}, if_instr,    32'h0);
    chk({tag, "_cnt"},   fetch_count, 32'h0);
    chk({tag, "_addr"},  imem_addr,   32'h0);
`ifdef MISALIGN_TRAP_EN
    chk({tag, "_merr"},  {31'b0, misalign_err}, 32'h0);
`endif
  endtask

  // ---------------------------------------------------------------------
  // Main test
  // ---------------------------------------------------------------------
  initial begin : main
    logic [31:0] e;
    logic [31:0] tgt;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    logic        hold_prev;
    int          beats;

    // Vector table. Each row gives the inputs driven for one cycle and the
    // outputs expected after the following rising edge. pc and instr are
    // only compared while the slot is valid.
    //   ready hlt rv  rpc            ev  pc             instr          cnt  addr
    add(1, 0, 0, 32'h0,          0, 32'h0,          32'h0,          0,  32'h0);          // BOOT edge
    add(1, 0, 0, 32'h0,          1, 32'h0,          32'h0,          0,  32'h4);
    add(1, 0, 0, 32'h0,          1, 32'h4,          32'h1,          1,  32'h8);
    add(1, 0, 0, 32'h0,          1, 32'h8,          32'h2,          2,  32'hC);
    add(1, 0, 0, 32'h0,          1, 32'hC,          32'h3,          3,  32'h10);
    add(1, 0, 0, 32'h0,          1, 32'h10,         32'h4,          4,  32'h14);
    add(1, 0, 0, 32'h0,          1, 32'h14,         32'h5,          5,  32'h18);
    add(0, 0, 0, 32'h0,          1, 32'h14,         32'h5,          5,  32'h18);         // backpressure
    add(0, 0, 0, 32'h0,          1, 32'h14,         32'h5,          5,  32'h18);
    add(0, 0, 0, 32'h0,          1, 32'h14,         32'h5,          5,  32'h18);
    add(1, 0, 0, 32'h0,          1, 32'h18,         32'h6,          6,  32'h1C);
    add(1, 0, 0, 32'h0,          1, 32'h1C,         32'h7,          7,  32'h20);
    add(1, 0, 1, 32'h100,        0, 32'h0,          32'h0,          8,  32'h100);        // redirect
    add(1, 0, 0, 32'h0,          1, 32'h100,        32'h40,         8,  32'h104);
    add(1, 0, 0, 32'h0,          1, 32'h104,        32'h41,         9,  32'h108);
    add(1, 1, 0, 32'h0,          1, 32'h108,        32'h42,         10, 32'h10C);        // halt
    add(1, 1, 0, 32'h0,          0, 32'h0,          32'h0,          11, 32'h10C);
    add(1, 1, 0, 32'h0,          0, 32'h0,          32'h0,          11, 32'h10C);
    add(1, 1, 0, 32'h0,          0, 32'h0,          32'h0,          11, 32'h10C);
    add(1, 0, 0, 32'h0,          0, 32'h0,          32'h0,          11, 32'h10C);        // resume
    add(1, 0, 0, 32'h0,          1, 32'h10C,        32'h43,         11, 32'h110);
    add(1, 1, 0, 32'h0,          1, 32'h110,        32'h44,         12, 32'h114);
    add(1, 1, 1, 32'h200,        0, 32'h0,          32'h0,          13, 32'h200);        // redirect in HALT
    add(1, 0, 0, 32'h0,          1, 32'h200,        32'h80,         13, 32'h204);
    add(1, 0, 1, 32'hFFFF_FFF8,  0, 32'h0,          32'h0,          14, 32'hFFFF_FFF8);  // wrap
    add(1, 0, 0, 32'h0,          1, 32'hFFFF_FFF8,  32'h3FFF_FFFE,  14, 32'hFFFF_FFFC);
    add(1, 0, 0, 32'h0,          1, 32'hFFFF_FFFC,  32'h3FFF_FFFF,  15, 32'h0);
    add(1, 0, 0, 32'h0,          1, 32'h0,          32'h0,          16, 32'h4);
    add(1, 0, 0, 32'h0,          1, 32'h4,          32'h1,          17, 32'h8);

    // Reset: hold for two cycles, then release at a falling edge.
    drive(0, 0, 0, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset_values("rst0");

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ready, vecs[i].hlt, vecs[i].rv, vecs[i].rpc);
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].e_valid});
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_pc", i),    if_pc,    vecs[i].e_pc);
        chk($sformatf("v%0d_instr", i), if_instr, vecs[i].e_instr);
      end
      chk($sformatf("v%0d_cnt", i),  fetch_count, vecs[i].e_cnt);
      chk($sformatf("v%0d_addr", i), imem_addr,   vecs[i].e_addr);
    end

    // Misaligned redirect while the slot holds 4/1. That beat is accepted.
    drive(1, 0, 1, 32'h102);
    @(negedge clk);
    chk("mis_valid", {31'b0, if_valid}, 32'h0);
    chk("mis_cnt",   fetch_count,       32'd18);
`ifdef MISALIGN_TRAP_EN
    chk("mis_addr",  imem_addr,              32'h102);
    chk("mis_err",   {31'b0, misalign_err},  32'h1);
    drive(1, 0, 0, 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("mis_stuck_valid", {31'b0, if_valid},     32'h0);
      chk("mis_stuck_addr",  imem_addr,             32'h102);
      chk("mis_stuck_err",   {31'b0, misalign_err}, 32'h1);
    end
    drive(1, 0, 1, 32'h200);
    @(negedge clk);
    chk("mis_redir_valid", {31'b0, if_valid},     32'h0);
    chk("mis_redir_addr",  imem_addr,             32'h200);
    drive(1, 0, 0, 32'h0);
    @(negedge clk);
    chk("mis_resume_valid", {31'b0, if_valid},     32'h1);
    chk("mis_resume_pc",    if_pc,                 32'h200);
    chk("mis_resume_instr", if_instr,              32'h80);
    chk("mis_resume_err",   {31'b0, misalign_err}, 32'h1);
`else
    chk("mis_addr", imem_addr, 32'h100);
    drive(1, 0, 0, 32'h0);
    @(negedge clk);
    chk("mis_next_valid", {31'b0, if_valid}, 32'h1);
    chk("mis_next_pc",    if_pc,             32'h100);
    chk("mis_next_instr", if_instr,          32'h40);
    chk("mis_next_addr",  imem_addr,         32'h104);
`endif

    // Asynchronous reset mid-stream. Outputs must clear before the next edge.
    drive(0, 0, 0, 32'h0);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_values("rst_mid");
    @(negedge clk);
    rst = 1'b0;

    // BOOT cycle, then randomized traffic against the stream model.
    @(negedge clk);
    exp_q.delete();
    exp_q.push_back(32'h0);
    beats     = 0;
    hold_prev = 1'b0;
    prev_pc    = 32'h0;
    prev_instr = 32'h0;

    for (int c = 0; c < 3000; c++) begin
      if_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        halt = ~halt;
      end
      redirect_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) begin
        redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      end else begin
        redirect_pc = 32'($urandom_range(0, 32'h3FF));
      end
`ifdef MISALIGN_TRAP_EN
      redirect_pc = {redirect_pc[31:2], 2'b00};
`endif

      chk("rnd_cnt", fetch_count, 32'(beats));

      if (hold_prev) begin
        chk("rnd_hold_valid", {31'b0, if_valid}, 32'h1);
        chk("rnd_hold_pc",    if_pc,             prev_pc);
        chk("rnd_hold_instr", if_instr,          prev_instr);
      end

      if (if_valid && if_ready) begin
        e = exp_q.pop_front();
        chk("rnd_beat_pc",    if_pc,    e);
        chk("rnd_beat_instr", if_instr, {2'b00, e[31:2]});
        exp_q.push_back(e + 32'd4);
        beats++;
      end

      hold_prev  = if_valid && !if_ready && !redirect_valid;
      prev_pc    = if_pc;
      prev_instr = if_instr;

      if (redirect_valid) begin
        tgt = {redirect_pc[31:2], 2'b00};
        exp_q.delete();
        exp_q.push_back(tgt);
      end

      @(negedge clk);
    end

    chk("rnd_progress", {31'b0, (beats > 500)}, 32'h1);

    // Final report.
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
